// File: rtl/multislope_if.sv
// Bus between the multislope run-up/run-down sequencer and its surroundings:
// timebase, conversion request, comparator in; analog switches and results out.
interface multislope_if #(
  parameter int RUNW  = 16,
  parameter int FINEW = 16
);
  logic                   clkdiv;
  logic                   start;
  logic [RUNW-1:0]        nruns;
  logic                   comp;
  logic                   sw_in;
  logic                   sw_pos;
  logic                   sw_neg;
  logic                   busy;
  logic                   done;
  logic signed [RUNW:0]   result_up;
  logic [FINEW-1:0]       result_fine;
  logic                   rd_dir;
  logic                   overflow;

  modport slave (
    input  clkdiv, start, nruns, comp,
    output sw_in, sw_pos, sw_neg, busy, done, result_up, result_fine, rd_dir, overflow
  );

  modport master (
    output clkdiv, start, nruns, comp,
    input  sw_in, sw_pos, sw_neg, busy, done, result_up, result_fine, rd_dir, overflow
  );
endinterface

// File: rtl/multislope_seq.sv
// Multi-slope integrating ADC sequencer: nr full clkdiv periods of run-up with a
// per-period reference choice, then a clk-resolution run-down until the comparator flips.
module multislope_seq #(
  parameter int RUNW  = 16,
  parameter int FINEW = 16
) (
  input  logic         clk,
  input  logic         rst,
  multislope_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALIGN   = 3'd1,
    S_RUNUP   = 3'd2,
    S_RUNDOWN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [RUNW-1:0]        RUN_ONE  = {{(RUNW-1){1'b0}}, 1'b1};
  localparam logic signed [RUNW:0]   ACC_ONE  = {{RUNW{1'b0}}, 1'b1};
  localparam logic [FINEW-1:0]       FINE_ONE = {{(FINEW-1){1'b0}}, 1'b1};
  localparam logic [FINEW-1:0]       FINE_MAX = {FINEW{1'b1}};

  state_t                r_state, w_state_nxt;
  logic                  r_clkdiv_q, r_comp_m, r_comp_s;
  logic                  w_tick;
  logic [RUNW-1:0]       r_nr, w_nr_nxt, r_runcnt, w_runcnt_nxt;
  logic signed [RUNW:0]  r_acc, w_acc_nxt, w_acc_step;
  logic [FINEW-1:0]      r_fine, w_fine_nxt, w_fine_inc;
  logic                  r_cmp0, w_cmp0_nxt, r_rd_dir_i, w_rd_dir_i_nxt;
  logic                  r_sw_in, w_sw_in_nxt, r_sw_pos, w_sw_pos_nxt, r_sw_neg, w_sw_neg_nxt;
  logic                  r_busy, w_busy_nxt, r_done, w_done_nxt;
  logic signed [RUNW:0]  r_result_up, w_result_up_nxt;
  logic [FINEW-1:0]      r_result_fine, w_result_fine_nxt;
  logic                  r_rd_dir, w_rd_dir_nxt, r_overflow, w_overflow_nxt;

  assign w_tick     = bus.clkdiv & ~r_clkdiv_q;
  // comp_s high means the integrator is positive, so that period must pull it down.
  assign w_acc_step = r_comp_s ? (r_acc - ACC_ONE) : (r_acc + ACC_ONE);
  assign w_fine_inc = r_fine + FINE_ONE;

  // Next-state and next-output decode for the conversion sequence.
  always_comb begin
    w_state_nxt       = r_state;
    w_nr_nxt          = r_nr;
    w_runcnt_nxt      = r_runcnt;
    w_acc_nxt         = r_acc;
    w_fine_nxt        = r_fine;
    w_cmp0_nxt        = r_cmp0;
    w_rd_dir_i_nxt    = r_rd_dir_i;
    w_sw_in_nxt       = r_sw_in;
    w_sw_pos_nxt      = r_sw_pos;
    w_sw_neg_nxt      = r_sw_neg;
    w_done_nxt        = 1'b0;
    w_result_up_nxt   = r_result_up;
    w_result_fine_nxt = r_result_fine;
    w_rd_dir_nxt      = r_rd_dir;
    w_overflow_nxt    = r_overflow;
    case (r_state)
      S_IDLE: begin
        w_sw_in_nxt  = 1'b0;
        w_sw_pos_nxt = 1'b0;
        w_sw_neg_nxt = 1'b0;
        if (bus.start) begin
          w_nr_nxt     = (bus.nruns == {RUNW{1'b0}}) ? RUN_ONE : bus.nruns;
          w_acc_nxt    = {(RUNW+1){1'b0}};
          w_runcnt_nxt = {RUNW{1'b0}};
          w_fine_nxt   = {FINEW{1'b0}};
          w_state_nxt  = S_ALIGN;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      S_ALIGN: begin
        if (w_tick) begin
          w_state_nxt  = S_RUNUP;
          w_sw_in_nxt  = 1'b1;
          w_sw_pos_nxt = ~r_comp_s;
          w_sw_neg_nxt = r_comp_s;
          w_acc_nxt    = w_acc_step;
          w_runcnt_nxt = RUN_ONE;
        end else begin
          w_state_nxt  = S_ALIGN;
        end
      end
      S_RUNUP: begin
        if (w_tick && (r_runcnt == r_nr)) begin
          w_state_nxt    = S_RUNDOWN;
          w_sw_in_nxt    = 1'b0;
          w_rd_dir_i_nxt = ~r_comp_s;
          w_sw_pos_nxt   = ~r_comp_s;
          w_sw_neg_nxt   = r_comp_s;
          w_cmp0_nxt     = r_comp_s;
          w_fine_nxt     = {FINEW{1'b0}};
        end else if (w_tick) begin
          w_sw_pos_nxt = ~r_comp_s;
          w_sw_neg_nxt = r_comp_s;
          w_acc_nxt    = w_acc_step;
          w_runcnt_nxt = r_runcnt + RUN_ONE;
        end else begin
          w_state_nxt  = S_RUNUP;
        end
      end
      S_RUNDOWN: begin
        w_fine_nxt = w_fine_inc;
        // A comparator flip wins over saturation landing in the same cycle.
        if ((r_comp_s != r_cmp0) || (w_fine_inc == FINE_MAX)) begin
          w_state_nxt       = S_DONE;
          w_sw_pos_nxt      = 1'b0;
          w_sw_neg_nxt      = 1'b0;
          w_done_nxt        = 1'b1;
          w_result_up_nxt   = r_acc;
          w_result_fine_nxt = w_fine_inc;
          w_rd_dir_nxt      = r_rd_dir_i;
          w_overflow_nxt    = (r_comp_s == r_cmp0);
        end else begin
          w_state_nxt       = S_RUNDOWN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_sw_in_nxt  = 1'b0;
        w_sw_pos_nxt = 1'b0;
        w_sw_neg_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, synchronisers, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_clkdiv_q    <= 1'b0;
      r_comp_m      <= 1'b0;
      r_comp_s      <= 1'b0;
      r_nr          <= {RUNW{1'b0}};
      r_runcnt      <= {RUNW{1'b0}};
      r_acc         <= {(RUNW+1){1'b0}};
      r_fine        <= {FINEW{1'b0}};
      r_cmp0        <= 1'b0;
      r_rd_dir_i    <= 1'b0;
      r_sw_in       <= 1'b0;
      r_sw_pos      <= 1'b0;
      r_sw_neg      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result_up   <= {(RUNW+1){1'b0}};
      r_result_fine <= {FINEW{1'b0}};
      r_rd_dir      <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_clkdiv_q    <= bus.clkdiv;
      r_comp_m      <= bus.comp;
      r_comp_s      <= r_comp_m;
      r_nr          <= w_nr_nxt;
      r_runcnt      <= w_runcnt_nxt;
      r_acc         <= w_acc_nxt;
      r_fine        <= w_fine_nxt;
      r_cmp0        <= w_cmp0_nxt;
      r_rd_dir_i    <= w_rd_dir_i_nxt;
      r_sw_in       <= w_sw_in_nxt;
      r_sw_pos      <= w_sw_pos_nxt;
      r_sw_neg      <= w_sw_neg_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_result_up   <= w_result_up_nxt;
      r_result_fine <= w_result_fine_nxt;
      r_rd_dir      <= w_rd_dir_nxt;
      r_overflow    <= w_overflow_nxt;
    end
  end

  assign bus.sw_in       = r_sw_in;
  assign bus.sw_pos      = r_sw_pos;
  assign bus.sw_neg      = r_sw_neg;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result_up   = r_result_up;
  assign bus.result_fine = r_result_fine;
  assign bus.rd_dir      = r_rd_dir;
  assign bus.overflow    = r_overflow;

endmodule
